// File: rtl/pipe_pc_ifid.sv
// Fetch-side register block: program counter plus IF/ID pipeline register with stall/flush,
// saturating fetch/bubble counters and a sticky stall watchdog.
module pipe_pc_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      npc,
  input  logic [31:0]      pc4,
  input  logic [31:0]      ins,
  input  logic             wpcir,
  input  logic             flush,
  input  logic             clear_cnt,
  output logic [31:0]      pc,
  output logic [31:0]      dpc4,
  output logic [31:0]      inst,
  output logic             dvalid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             stall_timeout
);

  localparam logic [7:0] MaxStall = 8'(MAX_STALL);

  logic [31:0]      r_pc, r_dpc4, r_inst;
  logic             r_dvalid;
  logic [CNT_W-1:0] r_fetch_cnt, r_bubble_cnt;
  logic [7:0]       r_stall_run;
  logic             r_timeout;

  logic             w_fetch;
  logic [CNT_W-1:0] w_fetch_nxt, w_bubble_nxt;
  logic [7:0]       w_run_nxt;

  always_comb begin
    w_fetch      = wpcir & ~flush;
    w_fetch_nxt  = (r_fetch_cnt == '1) ? r_fetch_cnt : r_fetch_cnt + 1'b1;
    w_bubble_nxt = (r_bubble_cnt == '1) ? r_bubble_cnt : r_bubble_cnt + 1'b1;
    w_run_nxt    = (r_stall_run >= MaxStall) ? MaxStall : r_stall_run + 8'd1;
  end

  // PC and IF/ID: a stall holds everything, and an unresolved flush is ignored while stalled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc     <= RESET_PC;
      r_dpc4   <= 32'h0;
      r_inst   <= 32'h0;
      r_dvalid <= 1'b0;
    end else if (wpcir) begin
      r_pc     <= npc;
      r_dpc4   <= pc4;
      r_inst   <= flush ? 32'h0 : ins;
      r_dvalid <= ~flush;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_stall_run  <= 8'd0;
      r_timeout    <= 1'b0;
    end else if (clear_cnt) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_stall_run  <= 8'd0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_fetch) r_fetch_cnt <= w_fetch_nxt;
      else         r_bubble_cnt <= w_bubble_nxt;
      if (wpcir) begin
        r_stall_run <= 8'd0;
      end else begin
        r_stall_run <= w_run_nxt;
        if (w_run_nxt == MaxStall) r_timeout <= 1'b1;
      end
    end
  end

  assign pc            = r_pc;
  assign dpc4          = r_dpc4;
  assign inst          = r_inst;
  assign dvalid        = r_dvalid;
  assign fetch_cnt     = r_fetch_cnt;
  assign bubble_cnt    = r_bubble_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_pc_ifid.sv
// Bench for pipe_pc_ifid: directed literal scenarios plus randomized traffic checked every
// cycle against an event-counting model.
module tb_pipe_pc_ifid;

  localparam logic [31:0] RP = 32'h100;
  localparam int          CW = 4;
  localparam int          MS = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   npc = '0, pc4 = '0, ins = '0;
  logic          wpcir = 1'b0, flush = 1'b0, clear_cnt = 1'b0;
  logic [31:0]   pc, dpc4, inst;
  logic          dvalid, stall_timeout;
  logic [CW-1:0] fetch_cnt, bubble_cnt;

  always #5 clock = ~clock;

  pipe_pc_ifid #(.RESET_PC(RP), .CNT_W(CW), .MAX_STALL(MS)) dut (
    .clock(clock), .resetn(resetn), .npc(npc), .pc4(pc4), .ins(ins), .wpcir(wpcir),
    .flush(flush), .clear_cnt(clear_cnt), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt), .stall_timeout(stall_timeout)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: counts events as unbounded integers; saturation applied only when compared.
  logic [31:0] m_pc, m_dpc4, m_inst;
  bit          m_dv, m_to;
  int          m_fetch, m_bub, m_run;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_pc = RP; m_dpc4 = 0; m_inst = 0; m_dv = 0;
      m_fetch = 0; m_bub = 0; m_run = 0; m_to = 0;
    end else begin
      if (clear_cnt) begin
        m_fetch = 0; m_bub = 0; m_run = 0; m_to = 0;
      end else begin
        if (wpcir && !flush) m_fetch++;
        else                 m_bub++;
        if (wpcir) m_run = 0;
        else       m_run++;
        if (m_run >= MS) m_to = 1;
      end
      if (wpcir) begin
        m_pc   = npc;
        m_dpc4 = pc4;
        m_inst = flush ? 32'h0 : ins;
        m_dv   = !flush;
      end
    end
  end

  function automatic logic [31:0] sat(input int n);
    return (n > (1 << CW) - 1) ? ((1 << CW) - 1) : n;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("dpc4", dpc4, m_dpc4);
      chk("inst", inst, m_inst);
      chk("dvalid", 32'(dvalid), 32'(m_dv));
      chk("fetch_cnt", 32'(fetch_cnt), sat(m_fetch));
      chk("bubble_cnt", 32'(bubble_cnt), sat(m_bub));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    end
  end

  task automatic drive(input logic w, input logic f, input logic c, input logic [31:0] n,
                       input logic [31:0] p, input logic [31:0] i);
    wpcir = w; flush = f; clear_cnt = c; npc = n; pc4 = p; ins = i;
    @(negedge clock);
  endtask

  initial begin
    // Come out of reset and run a little so the async reset below has state to discard.
    @(negedge clock);
    resetn = 1'b1;
    drive(1, 0, 0, 32'h200, 32'h204, 32'hAAAA_0001);
    drive(0, 0, 0, 32'h300, 32'h304, 32'hAAAA_0002);

    // Asynchronous reset mid-cycle.
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("rst pc", pc, 32'h100);
    chk("rst dpc4", dpc4, 32'h0);
    chk("rst inst", inst, 32'h0);
    chk("rst dvalid", 32'(dvalid), 32'h0);
    chk("rst fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("rst bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("rst timeout", 32'(stall_timeout), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    cmp_en = 1'b1;

    // First edge after release: load npc and a straight-line instruction.
    drive(1, 0, 0, 32'h104, 32'h4, 32'h2001_0005);
    chk("pc after release", pc, 32'h104);
    chk("fetch inst", inst, 32'h2001_0005);
    chk("fetch dpc4", dpc4, 32'h4);
    chk("fetch dvalid", 32'(dvalid), 32'h1);
    chk("fetch cnt 1", 32'(fetch_cnt), 32'h1);

    // Two stalls while inputs change.
    drive(0, 0, 0, 32'h208, 32'h8, 32'hDEAD_BEEF);
    drive(0, 0, 0, 32'h20C, 32'hC, 32'hBEEF_DEAD);
    chk("stall pc", pc, 32'h104);
    chk("stall inst", inst, 32'h2001_0005);
    chk("stall dvalid", 32'(dvalid), 32'h1);
    chk("stall bubble", 32'(bubble_cnt), 32'h2);
    chk("stall fetch", 32'(fetch_cnt), 32'h1);

    // Flush while advancing, then flush while stalled.
    drive(1, 1, 0, 32'h300, 32'h10, 32'h1234_5678);
    chk("flush pc", pc, 32'h300);
    chk("flush inst", inst, 32'h0);
    chk("flush dvalid", 32'(dvalid), 32'h0);
    chk("flush dpc4", dpc4, 32'h10);
    chk("flush bubble", 32'(bubble_cnt), 32'h3);
    drive(0, 1, 0, 32'h400, 32'h20, 32'h8765_4321);
    chk("flush-stall pc", pc, 32'h300);
    chk("flush-stall dpc4", dpc4, 32'h10);
    chk("flush-stall bubble", 32'(bubble_cnt), 32'h4);
    chk("flush-stall fetch", 32'(fetch_cnt), 32'h1);

    // Clear, then saturate the fetch counter, then clear against a valid fetch.
    drive(1, 0, 1, 32'h500, 32'h24, 32'h1);
    chk("clear fetch", 32'(fetch_cnt), 32'h0);
    chk("clear bubble", 32'(bubble_cnt), 32'h0);
    for (int k = 0; k < 20; k++) drive(1, 0, 0, 32'h600 + 4 * k, 32'h30 + 4 * k, 32'h100 + k);
    chk("sat fetch", 32'(fetch_cnt), 32'hF);
    drive(1, 0, 1, 32'h700, 32'h80, 32'h2);
    chk("clear beats fetch", 32'(fetch_cnt), 32'h0);
    chk("clear keeps ifid", inst, 32'h2);

    // Watchdog: 2 stalls, 1 advance, 3 stalls.
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("wd run1", 32'(stall_timeout), 32'h0);
    drive(1, 0, 0, 32'h800, 32'h84, 32'h3);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("wd 2nd stall", 32'(stall_timeout), 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("wd 3rd stall", 32'(stall_timeout), 32'h1);
    drive(1, 0, 0, 32'h900, 32'h88, 32'h4);
    chk("wd sticky", 32'(stall_timeout), 32'h1);
    drive(1, 0, 1, 32'hA00, 32'h8C, 32'h5);
    chk("wd clear", 32'(stall_timeout), 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 4), $urandom, $urandom, $urandom);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_pc_ifid.md
# pipe_pc_ifid

Sequential front-end register block of the five-stage MIPS32 pipeline: holds the program counter driving instruction fetch and the IF/ID pipeline register consuming the fetch stage's `pc4`/`ins`. It applies the ID-stage stall (`wpcir`) and branch/jump flush, tracks instruction validity, and keeps saturating fetch/bubble counters plus a sticky stall watchdog for debug.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 16: width of the performance counters.
- `MAX_STALL`, 8: consecutive stall cycles that trip the watchdog; legal range 1..255.

Ports:
- `clock` in 1: pipeline clock; all state updates on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `npc` in 32: next PC chosen by fetch stage.
- `pc4` in 32: PC+4 of the instruction being fetched.
- `ins` in 32: fetched instruction; already zero when fetch-side flush applies.
- `wpcir` in 1: 1 = advance PC and IF/ID; 0 = stall (hold both).
- `flush` in 1: taken branch/jump resolved in ID; the instruction latched this edge becomes a bubble.
- `clear_cnt` in 1: synchronous clear of counters, stall run and watchdog.
- `pc` out 32: current fetch PC.
- `dpc4` out 32: PC+4 of instruction in ID.
- `inst` out 32: instruction in ID.
- `dvalid` out 1: `inst` is a real (non-bubble) instruction.
- `fetch_cnt` out CNT_W: valid instructions latched into ID.
- `bubble_cnt` out CNT_W: cycles ID received a bubble or held.
- `stall_timeout` out 1: sticky; stall run reached MAX_STALL.

## Operation
- PC register: `wpcir`=1 -> `pc` <= `npc`; `wpcir`=0 -> hold. `flush` never affects `pc` (fetch stage already selects the redirect target in `npc`).
- IF/ID register, priority order:
  - `wpcir`=0: `dpc4`, `inst`, `dvalid` hold; `flush` ignored (the branch in ID is not yet resolved while stalled).
  - `wpcir`=1, `flush`=1: `dpc4` <= `pc4`, `inst` <= 0, `dvalid` <= 0.
  - `wpcir`=1, `flush`=0: `dpc4` <= `pc4`, `inst` <= `ins`, `dvalid` <= 1.
- Counters (each edge, `clear_cnt`=0):
  - `fetch_cnt` +1 when `wpcir`=1 and `flush`=0.
  - `bubble_cnt` +1 when `wpcir`=0 or `flush`=1.
  - Both saturate at all-ones; no wrap.
- Watchdog: internal 8-bit stall run counts consecutive `wpcir`=0 edges, resets to 0 on any `wpcir`=1 edge, saturates at MAX_STALL. The edge on which it reaches MAX_STALL sets `stall_timeout`, which stays 1 until reset or `clear_cnt`.
- `clear_cnt`=1: counters, stall run and `stall_timeout` <= 0 on that edge; clear wins over simultaneous increment or set. PC and IF/ID unaffected.

## Timing
- Reset (async, immediate): `pc`=RESET_PC, `dpc4`=0, `inst`=0, `dvalid`=0, `fetch_cnt`=0, `bubble_cnt`=0, `stall_timeout`=0, stall run=0. Reset mid-stall or mid-flush discards all state; first posedge after release with `wpcir`=1 loads `npc`.
- Latency: `npc` -> `pc` 1 cycle; `ins`/`pc4` -> `inst`/`dpc4` 1 cycle. Instruction memory samples `pc` on the opposite clock edge, so `ins` is stable before the next posedge.
- Outputs are pure register outputs; no combinational input-to-output path.
- Watchdog with MAX_STALL=N: `stall_timeout` rises after the N-th consecutive stalled posedge.

## Test plan
- Reset: drive `resetn`=0 asynchronously mid-cycle with RESET_PC=32'h100 -> all outputs at reset values immediately; release, `npc`=32'h104, `wpcir`=1 -> `pc`=32'h104 after one posedge.
- Straight-line fetch: `ins`=32'h2001_0005, `pc4`=32'h4, `wpcir`=1, `flush`=0 -> next cycle `inst`=32'h2001_0005, `dpc4`=32'h4, `dvalid`=1, `fetch_cnt`=1.
- Stall: `wpcir`=0 for 2 cycles while `npc`/`ins` change -> `pc`, `inst`, `dvalid` unchanged; `bubble_cnt`=+2; `fetch_cnt` unchanged.
- Flush and flush-during-stall: `flush`=1, `wpcir`=1 -> `inst`=0, `dvalid`=0, `bubble_cnt`+1, `pc`=`npc`; `flush`=1, `wpcir`=0 -> everything holds, `bubble_cnt`+1 only.
- Saturation/clear: CNT_W=4, 20 valid fetches -> `fetch_cnt`=4'hF; `clear_cnt`=1 together with a valid fetch -> `fetch_cnt`=0.
- Watchdog: MAX_STALL=3, 2 stalls then 1 advance then 3 stalls -> `stall_timeout` 0 until third stall of second run, then 1 and stays 1 after `wpcir` returns to 1; `clear_cnt` -> 0.
